mem_responder: RTL and testbench

Multi-cycle data-memory responder serving the pipelined datapath's memory stage through the Stall/Done request protocol. It accepts one read or write at a time, holds Stall while the access is in flight, and pulses Done with read data when the access completes. A single-entry last-address tag lets a repeat access to the same word complete in the request cycle with CacheHit set. Storage is a word-addressed array; contents are not initialised by reset.

---
 rtl/mem_responder.sv | 154 +++++++++++++++
 tb/tb_mem_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Multi-cycle data-memory responder (Stall/Done protocol) with a
//            single-entry last-word tag for same-cycle repeat accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Wr,
    input  logic        Rd,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);

    localparam int        c_DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] c_LAST_CNT = 4'(LATENCY - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_tag;
    logic                r_tag_valid;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_data;
    logic                r_wr;

    logic [15:0]         r_mem [c_DEPTH];

    logic [ADDR_W-1:0]   w_word;
    logic                w_req;
    logic                w_err;
    logic                w_hit;
    logic                w_accept;
    logic                w_finish;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [15:0]         w_wdata;
    logic [15:0]         w_dout;
    logic                w_done;
    logic                w_stall;
    logic                w_chit;

    assign w_word = Addr[ADDR_W:1];
    assign w_req  = Rd | Wr;

    generate
        if (ADDR_W < 15) begin : g_unused_addr
            logic w_unused_addr;
            assign w_unused_addr = &{1'b0, Addr[15:ADDR_W+1]};
        end
    endgenerate

    always_comb begin
        w_next_state = r_state;
        w_err        = 1'b0;
        w_hit        = 1'b0;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_we         = 1'b0;
        w_waddr      = w_word;
        w_wdata      = DataIn;
        w_dout       = 16'h0000;
        w_done       = 1'b0;
        w_stall      = 1'b0;
        w_chit       = 1'b0;
        case (r_state)
            IDLE: begin
                w_err = w_req & (Addr[0] | (Rd & Wr));
                w_hit = w_req & ~w_err & r_tag_valid & (w_word == r_tag);
                if (w_hit) begin
                    w_done = 1'b1;
                    w_chit = 1'b1;
                    w_we   = Wr;
                    w_dout = Rd ? r_mem[w_word] : 16'h0000;
                end else if (w_req && !w_err) begin
                    w_stall      = 1'b1;
                    w_accept     = 1'b1;
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                w_waddr = r_addr;
                w_wdata = r_data;
                if (r_cnt == c_LAST_CNT) begin
                    w_done       = 1'b1;
                    w_finish     = 1'b1;
                    w_we         = r_wr;
                    w_dout       = r_wr ? 16'h0000 : r_mem[r_addr];
                    w_next_state = IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, independent of the inputs.
    assign DataOut  = Rst ? w_dout  : 16'h0000;
    assign Done     = Rst & w_done;
    assign Stall    = Rst & w_stall;
    assign CacheHit = Rst & w_chit;
    assign err      = Rst & w_err;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
            r_addr      <= '0;
            r_data      <= 16'h0000;
            r_wr        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt  <= 4'd0;
                r_addr <= w_word;
                r_data <= DataIn;
                r_wr   <= Wr;
            end else if (r_state == BUSY) begin
                r_cnt <= w_finish ? 4'd0 : r_cnt + 4'd1;
            end
            if (w_finish) begin
                r_tag       <= r_addr;
                r_tag_valid <= 1'b1;
            end
        end
    end

    // Storage is not reset; gating with Rst drops any write pending at reset.
    always_ff @(posedge Clk) begin
        if (Rst && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Scoreboard bench for mem_responder with directed accesses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int c_LAT = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] din;
    logic        wr;
    logic        rd;
    logic [15:0] dout;
    logic        done;
    logic        stall;
    logic        chit;
    logic        err;

    int compared   = 0;
    int mismatched = 0;

    logic [16:0] sb[$];

    mem_responder #(.LATENCY(c_LAT), .ADDR_W(8)) dut (
        .Clk(clk), .Rst(rst_n), .Addr(addr), .DataIn(din), .Wr(wr), .Rd(rd),
        .DataOut(dout), .Done(done), .Stall(stall), .CacheHit(chit), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pops an expected response whenever Done is presented.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("done_stall_excl", 32'(done & stall), 32'd0);
            chk("err_excl", 32'(err & (done | stall)), 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [16:0] e;
                    e = sb.pop_front();
                    chk("cachehit", 32'(chit), 32'(e[16]));
                    chk("dataout", 32'(dout), 32'(e[15:0]));
                end
            end
        end
    end

    // Issue one access at posedge+1 and wait for its Done; expectation goes to the scoreboard.
    task automatic access(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic exp_hit, input logic [15:0] exp_d, input bit hold);
        int  stalls;
        bit  seen;
        rd = r; wr = w; addr = a; din = d;
        sb.push_back({exp_hit, exp_d});
        stalls = 0;
        seen   = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                if (stall) stalls++;
                @(posedge clk); #1;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("stall_cycles", 32'(stalls), exp_hit ? 32'd0 : 32'(c_LAT));
        @(posedge clk); #1;
        if (!hold) begin
            rd = 1'b0; wr = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = 16'h0; din = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_chit", 32'(chit), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write miss, then idle cycle check, then two back-to-back read hits.
        access(0, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 0);
        @(negedge clk);
        chk("post_write_done", 32'(done), 32'd0);
        chk("post_write_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        access(1, 0, 16'h0010, 16'h0000, 1, 16'hBEEF, 0);
        access(1, 0, 16'h0010, 16'h0000, 1, 16'hBEEF, 0);

        // Move the tag around so reads of 0x20 and 0x10 both miss.
        access(0, 1, 16'h0020, 16'h1234, 0, 16'h0000, 0);
        access(0, 1, 16'h0030, 16'h3333, 0, 16'h0000, 0);
        access(1, 0, 16'h0020, 16'h0000, 0, 16'h1234, 0);
        access(1, 0, 16'h0010, 16'h0000, 0, 16'hBEEF, 0);

        // Illegal requests: misaligned, then read+write.
        rd = 1'b1; addr = 16'h0011;
        @(negedge clk);
        chk("err_misalign", 32'(err), 32'd1);
        chk("err_misalign_stall", 32'(stall), 32'd0);
        chk("err_misalign_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rd = 1'b1; wr = 1'b1; addr = 16'h0030; din = 16'hFFFF;
        @(negedge clk);
        chk("err_rdwr", 32'(err), 32'd1);
        chk("err_rdwr_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        // Tag still 0x10 after the errors: repeat read hits.
        access(1, 0, 16'h0010, 16'h0000, 1, 16'hBEEF, 0);
        access(1, 0, 16'h0030, 16'h0000, 0, 16'h3333, 0);

        // Reset mid write-miss must abort the write.
        access(0, 1, 16'h0040, 16'hA5A5, 0, 16'h0000, 0);
        access(1, 0, 16'h0010, 16'h0000, 0, 16'hBEEF, 0);
        rd = 1'b0; wr = 1'b1; addr = 16'h0040; din = 16'h5555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_chit", 32'(chit), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        wr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(1, 0, 16'h0040, 16'h0000, 0, 16'hA5A5, 0);

        // Read held through its Done: one Done, then a hit on the next cycle.
        access(0, 1, 16'h0050, 16'h0BAD, 0, 16'h0000, 0);
        access(0, 1, 16'h0060, 16'h6666, 0, 16'h0000, 0);
        access(1, 0, 16'h0050, 16'h0000, 0, 16'h0BAD, 1);
        access(1, 0, 16'h0050, 16'h0000, 1, 16'h0BAD, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
